req_arbiter: RTL and testbench
==============================

REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter PORTS, default 4, SHALL set the number of requesters; legal range 1..32.
REQ-002 Parameter ROUND_ROBIN, default 1, SHALL select the policy: 1 = round-robin, 0 = fixed priority.
REQ-003 Parameter BLOCK_ACK, default 1, SHALL select the release rule: 1 = hold grant until acknowledge, 0 = hold grant while request stays high.
REQ-004 Parameter LSB_HIGH_PRIORITY, default 0, SHALL select the priority order: 1 = index 0 highest, 0 = index PORTS-1 highest.
REQ-005 Derived CL_PORTS SHALL be ceil(log2(PORTS)), with a minimum of 1.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-008 request  input  PORTS  SHALL carry one request bit per requester.
REQ-009 acknowledge  input  PORTS  SHALL carry one release bit per requester; only the bit of the granted index is observed.
REQ-010 grant  output  PORTS  SHALL be registered and one-hot, or all zero.
REQ-011 grant_valid  output  1  SHALL be registered; high iff grant is nonzero.
REQ-012 grant_encoded  output  CL_PORTS  SHALL be registered and hold the binary index of grant; 0 when grant_valid is low.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant) and GRANTED (exactly one grant bit set).
REQ-014 In IDLE, if request is nonzero at a clock edge, the block SHALL assert the selected grant at that edge, giving 1-cycle latency; if request is zero, it SHALL stay in IDLE.
REQ-015 Fixed-priority selection SHALL choose the highest-priority set request bit according to LSB_HIGH_PRIORITY.
REQ-016 Round-robin selection SHALL first consider only requests strictly lower in priority than the last granted index, in the LSB_HIGH_PRIORITY order.
- If none of those are set, selection SHALL wrap and fall back to fixed priority over all requests.
- Example with LSB_HIGH_PRIORITY=1 and last grant = 2: order 3, 0, 1, 2.
REQ-017 The round-robin mask SHALL update only when a new grant is issued; at reset it SHALL place index 0 (LSB_HIGH_PRIORITY=1) or index PORTS-1 (LSB_HIGH_PRIORITY=0) at top priority.
REQ-018 With BLOCK_ACK=1 in GRANTED:
- The grant SHALL hold until acknowledge[grant_encoded] is sampled high.
- Deasserting the granted request SHALL NOT release the grant.
REQ-019 With BLOCK_ACK=0 in GRANTED, the grant SHALL hold while request[grant_encoded] is high and release when it is sampled low; acknowledge is ignored.
REQ-020 On a release edge, the block SHALL re-arbitrate in the same edge from the current request vector, with the just-released index at lowest round-robin priority.
- This gives back-to-back grants with no idle cycle.
- If no request is pending, the block SHALL go to IDLE.
REQ-021 A requester still requesting at its own release edge SHALL be re-granted only if no other request is pending (round-robin); under fixed priority it SHALL compete normally.
REQ-022 Higher-priority requests arriving during GRANTED SHALL NOT preempt the current grant.
REQ-023 Acknowledge bits of non-granted indices, and any acknowledge in IDLE, SHALL be ignored.
REQ-024 With PORTS=1, the block SHALL grant index 0 whenever request[0] is set, subject to the release rules above.

Reset
REQ-025 While rst is high, grant, grant_valid and grant_encoded SHALL be 0, the FSM SHALL be IDLE, and the round-robin mask SHALL be at its reset value.
- These values SHALL take effect asynchronously, without waiting for a clock edge.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately.
REQ-027 The first edge after rst deasserts SHALL arbitrate normally.

Verification (PORTS=4, ROUND_ROBIN=1, BLOCK_ACK=1, LSB_HIGH_PRIORITY=1 unless stated)
REQ-028 Reset: assert rst asynchronously mid-cycle while grant=4'b0100 -> outputs go 0 before the next edge; then request=4'b1111 -> first grant is 4'b0001.
REQ-029 Rotation: request=4'b1111 held, acknowledge of the granted index pulsed one cycle after each grant -> grant_encoded sequence 0,1,2,3,0 with no idle cycles.
REQ-030 Wrap: last grant index 3, then request=4'b1001 -> grant=4'b0001; next release with request=4'b1001 -> grant=4'b1000.
REQ-031 Hold: grant=4'b0100 with no acknowledge for 10 cycles while request changes to 4'b0001, and request[2] dropped -> grant stays 4'b0100; acknowledge[0] pulsed during this window -> no effect.
REQ-032 BLOCK_ACK=0, fixed priority (ROUND_ROBIN=0): request=4'b0110 -> grant 4'b0010; drop request[1] -> next edge grant 4'b0100; drop all -> grant_valid=0.
REQ-033 Idle: request=0 for 5 cycles after reset -> grant_valid stays 0 and grant_encoded stays 0.

Source files
------------

// File: rtl/req_arbiter.sv
// req_arbiter: registered one-hot request arbiter with fixed or round-robin
// priority and a selectable release rule (acknowledge or request drop).
module req_arbiter #(
  parameter int PORTS             = 4,
  parameter int ROUND_ROBIN       = 1,
  parameter int BLOCK_ACK         = 1,
  parameter int LSB_HIGH_PRIORITY = 0,
  parameter int CL_PORTS          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    request,
  input  logic [PORTS-1:0]    acknowledge,
  output logic [PORTS-1:0]    grant,
  output logic                grant_valid,
  output logic [CL_PORTS-1:0] grant_encoded
);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  // Reset value of the last-granted index: chosen so the wrap-around puts
  // the natural top-priority index first after reset.
  localparam logic [CL_PORTS-1:0] LAST_RST =
    (LSB_HIGH_PRIORITY != 0) ? CL_PORTS'(PORTS - 1) : '0;

  state_t              r_state, w_state_n;
  logic [PORTS-1:0]    r_grant, w_grant_n;
  logic                r_valid, w_valid_n;
  logic [CL_PORTS-1:0] r_enc, w_enc_n;
  logic [CL_PORTS-1:0] r_last, w_last_n;

  logic [PORTS-1:0]    w_mask;
  logic [31:0]         w_last_int;
  logic [CL_PORTS:0]   w_pick_rr;
  logic [CL_PORTS:0]   w_pick_fx;
  logic                w_sel_found;
  logic [CL_PORTS-1:0] w_sel_idx;
  logic                w_release;
  logic                w_arbitrate;

  // Highest-priority set bit of v: {found, index}. Scans from lowest to
  // highest priority so the last hit is the winner.
  function automatic logic [CL_PORTS:0] pick(input logic [PORTS-1:0] v);
    logic [CL_PORTS:0] res;
    res = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (LSB_HIGH_PRIORITY != 0) begin
        if (v[PORTS-1-k]) res = {1'b1, CL_PORTS'(PORTS - 1 - k)};
      end else begin
        if (v[k]) res = {1'b1, CL_PORTS'(k)};
      end
    end
    return res;
  endfunction

  // Round-robin mask: only indices strictly lower in priority than the last grant.
  always_comb begin
    w_mask     = '0;
    w_last_int = 32'(r_last);
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (LSB_HIGH_PRIORITY != 0) w_mask[i] = (i > w_last_int);
      else                        w_mask[i] = (i < w_last_int);
    end
  end

  // Winner selection: masked round-robin pick first, fixed priority as fallback.
  always_comb begin
    w_pick_rr = pick(request & w_mask);
    w_pick_fx = pick(request);
    if ((ROUND_ROBIN != 0) && w_pick_rr[CL_PORTS]) begin
      w_sel_found = 1'b1;
      w_sel_idx   = w_pick_rr[CL_PORTS-1:0];
    end else begin
      w_sel_found = w_pick_fx[CL_PORTS];
      w_sel_idx   = w_pick_fx[CL_PORTS-1:0];
    end
  end

  // Release condition for the currently held grant.
  always_comb begin
    if (BLOCK_ACK != 0) w_release = acknowledge[r_enc];
    else                w_release = ~request[r_enc];
  end

  // Next-state and next-output logic; release and re-grant share one edge.
  always_comb begin
    w_state_n   = r_state;
    w_grant_n   = r_grant;
    w_valid_n   = r_valid;
    w_enc_n     = r_enc;
    w_last_n    = r_last;
    w_arbitrate = 1'b0;
    case (r_state)
      S_IDLE:    w_arbitrate = 1'b1;
      S_GRANTED: w_arbitrate = w_release;
      default:   w_arbitrate = 1'b1;
    endcase
    if (w_arbitrate) begin
      if (w_sel_found) begin
        w_state_n = S_GRANTED;
        w_valid_n = 1'b1;
        w_enc_n   = w_sel_idx;
        w_last_n  = w_sel_idx;
        for (int unsigned i = 0; i < PORTS; i++) begin
          w_grant_n[i] = (i == 32'(w_sel_idx));
        end
      end else begin
        w_state_n = S_IDLE;
        w_valid_n = 1'b0;
        w_enc_n   = '0;
        w_grant_n = '0;
      end
    end
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_enc   <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_valid <= w_valid_n;
      r_enc   <= w_enc_n;
      r_last  <= w_last_n;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_valid;
  assign grant_encoded = r_enc;

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed scenarios plus randomized traffic against a
// priority-order reference model.
module tb_req_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] request, acknowledge;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_encoded;

  logic [3:0] req2, ack2;
  logic [3:0] g2;
  logic       v2;
  logic [1:0] e2;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state for the round-robin / acknowledge instance.
  int m_valid = 0;
  int m_idx   = 0;
  int m_last  = 3;

  req_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) dut (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded)
  );

  req_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) dut_fx (
    .clk(clk), .rst(rst), .request(req2), .acknowledge(ack2),
    .grant(g2), .grant_valid(v2), .grant_encoded(e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin order after last grant L is L+1, L+2, ... modulo 4.
  task automatic model_step;
    int start;
    int cand;
    bit found;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_last = 3;
    end else if (m_valid == 0 || acknowledge[m_idx] == 1'b1) begin
      start = m_last;
      found = 0;
      for (int k = 0; k < 4; k++) begin
        cand = (start + 1 + k) % 4;
        if (!found && request[cand]) begin
          found = 1; m_idx = cand; m_last = cand;
        end
      end
      m_valid = found ? 1 : 0;
      if (!found) m_idx = 0;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    g = (m_valid != 0) ? (4'b0001 << m_idx) : 4'b0000;
    return {g, (m_valid != 0), 2'(m_idx)};
  endfunction

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; request = '0; acknowledge = '0; req2 = '0; ack2 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; request = '0; acknowledge = '0; req2 = '0; ack2 = '0;
    #3;
    n_total++;
    if ({grant, grant_valid, grant_encoded} !== 7'b0) $display("FAIL reset_init got %b want 0", {grant, grant_valid, grant_encoded});
    else n_pass++;
    tick();
    rst = 1'b0;
    request = 4'b0100;
    tick();
    n_total++;
    if (grant !== 4'b0100) $display("FAIL reset_pregrant got %b want 0100", grant);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({grant, grant_valid, grant_encoded} !== 7'b0) $display("FAIL reset_async got %b want 0", {grant, grant_valid, grant_encoded});
    else n_pass++;
    tick();
    rst = 1'b0;
    request = 4'b1111;
    tick();
    n_total++;
    if (grant !== 4'b0001 || grant_encoded !== 2'd0) $display("FAIL reset_first got %b/%0d want 0001/0", grant, grant_encoded);
    else n_pass++;
  endtask

  task automatic test_idle;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (grant_valid !== 1'b0 || grant_encoded !== 2'd0) $display("FAIL idle got v=%b e=%0d want 0/0", grant_valid, grant_encoded);
      else n_pass++;
    end
  endtask

  task automatic test_rotation;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (grant_valid !== 1'b1 || grant_encoded !== 2'(exp_seq[k])) $display("FAIL rotation[%0d] got v=%b e=%0d want 1/%0d", k, grant_valid, grant_encoded, exp_seq[k]);
      else n_pass++;
      acknowledge = 4'b0001 << exp_seq[k];
      tick();
    end
    acknowledge = '0;
  endtask

  task automatic test_wrap;
    do_reset();
    request = 4'b1000;
    tick();
    n_total++;
    if (grant !== 4'b1000) $display("FAIL wrap_setup got %b want 1000", grant);
    else n_pass++;
    request = 4'b1001; acknowledge = 4'b1000;
    tick();
    n_total++;
    if (grant !== 4'b0001) $display("FAIL wrap_to0 got %b want 0001", grant);
    else n_pass++;
    acknowledge = 4'b0001;
    tick();
    n_total++;
    if (grant !== 4'b1000) $display("FAIL wrap_to3 got %b want 1000", grant);
    else n_pass++;
    acknowledge = '0;
  endtask

  task automatic test_hold;
    do_reset();
    request = 4'b0100;
    tick();
    for (int k = 0; k < 10; k++) begin
      request = (k < 3) ? 4'b0101 : 4'b0001;
      acknowledge = (k % 2 == 1) ? 4'b0001 : 4'b1010;
      tick();
      n_total++;
      if (grant !== 4'b0100) $display("FAIL hold[%0d] got %b want 0100", k, grant);
      else n_pass++;
    end
    acknowledge = 4'b0100;
    tick();
    n_total++;
    if (grant !== 4'b0001) $display("FAIL hold_release got %b want 0001", grant);
    else n_pass++;
    acknowledge = '0;
  endtask

  task automatic test_fixed_noack;
    do_reset();
    req2 = 4'b0110; ack2 = 4'b1111;
    tick();
    n_total++;
    if (g2 !== 4'b0010) $display("FAIL fixed_first got %b want 0010", g2);
    else n_pass++;
    tick();
    n_total++;
    if (g2 !== 4'b0010) $display("FAIL fixed_ackignored got %b want 0010", g2);
    else n_pass++;
    req2 = 4'b0100; ack2 = '0;
    tick();
    n_total++;
    if (g2 !== 4'b0100 || e2 !== 2'd2) $display("FAIL fixed_next got %b/%0d want 0100/2", g2, e2);
    else n_pass++;
    req2 = 4'b0000;
    tick();
    n_total++;
    if (v2 !== 1'b0 || g2 !== 4'b0000) $display("FAIL fixed_drop got v=%b g=%b want 0/0000", v2, g2);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [6:0] exp;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      request     = 4'($urandom);
      acknowledge = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      exp = model_out();
      n_total++;
      if ({grant, grant_valid, grant_encoded} !== exp) $display("FAIL random[%0d] got %b want %b", k, {grant, grant_valid, grant_encoded}, exp);
      else n_pass++;
    end
    request = '0; acknowledge = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_rotation();
    test_wrap();
    test_hold();
    test_fixed_noack();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
